// File: rtl/aes_spi_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_spi_rx_pkg
// Desc     : Shared constants and FSM state type for the AES SPI receive deframer.
// Revision : 1.0 - initial release
// ============================================================================
package aes_spi_rx_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = 128;
    localparam int BYTE_W      = 8;
    localparam int BCNT_W      = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/aes_spi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aes_spi_rx_fifo
// Desc     : Synchronous FIFO with a registered head output; a pop shows the
//            next entry on o_data the cycle after the handshake.
// Revision : 1.0 - initial release
// ============================================================================
module aes_spi_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int                c_ADDR_W  = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_PTR_ONE = {{c_ADDR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_ADDR_W:0] r_wr_ptr;
    logic [c_ADDR_W:0] r_rd_ptr;
    logic [WIDTH-1:0]  r_head;
    logic              w_do_push;
    logic              w_do_pop;
    logic [c_ADDR_W:0] w_rd_next;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                       (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign w_rd_next = w_do_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;
    assign o_data    = r_head;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            r_rd_ptr <= w_rd_next;
            // When the new head is the slot being written now, bypass the array.
            if (w_do_push || w_do_pop) begin
                r_head <= (w_rd_next == r_wr_ptr) ? i_data
                                                  : r_mem[w_rd_next[c_ADDR_W-1:0]];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : aes_spi_rx
// Desc     : 8-lane parallel SPI receive deframer; packs 16 strobed bytes into
//            128-bit blocks and streams them out of a block FIFO.
// Config   : AES_SPI_RX_SYNC_EN adds 2-flop synchronizers on all SPI pins.
// Revision : 1.0 - initial release
// ============================================================================
module aes_spi_rx
    import aes_spi_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [7:0]         spi_data,
    input  logic               spi_clk,
    input  logic               spi_cs_n,
    output logic [127:0]       blk_data,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [CNT_W-1:0]   blk_count,
    output logic               frame_err,
    output logic               overflow,
    input  logic               err_clr
);

    localparam int               c_PIN_W     = BYTE_W + 2;
    localparam logic [BCNT_W-1:0] c_LAST_BYTE = BCNT_W'(BLOCK_BYTES - 1);
    localparam logic [BCNT_W-1:0] c_BCNT_ONE  = {{(BCNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [c_PIN_W-1:0]  w_pins;
    logic [c_PIN_W-1:0]  w_pins_sync;
    logic [c_PIN_W-1:0]  r_smp;
    logic                r_clk_prev;
    logic                w_cs_n;
    logic                w_strobe;
    logic [BYTE_W-1:0]   w_byte;

    rx_state_t           r_state;
    logic [BLOCK_W-1:0]  r_shift;
    logic [BCNT_W-1:0]   r_byte_cnt;
    logic                r_armed;
    logic                r_frame_err;
    logic                r_overflow;
    logic [CNT_W-1:0]    r_blk_count;

    logic [BLOCK_W-1:0]  w_next_blk;
    logic                w_blk_done;
    logic                w_abort;
    logic                w_pop;
    logic                w_accept;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;

    assign w_pins = {spi_cs_n, spi_clk, spi_data};

`ifdef AES_SPI_RX_SYNC_EN
    logic [c_PIN_W-1:0] r_sync1;
    logic [c_PIN_W-1:0] r_sync2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_pins;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pins_sync = r_sync2;
`else
    assign w_pins_sync = w_pins;
`endif

    // Sampled chip-select resets to "asserted" so a frame already in flight at
    // reset release cannot arm the receiver until a real high is observed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_smp      <= '0;
            r_clk_prev <= 1'b0;
        end else begin
            r_smp      <= w_pins_sync;
            r_clk_prev <= r_smp[BYTE_W];
        end
    end

    assign w_cs_n   = r_smp[BYTE_W+1];
    assign w_strobe = r_smp[BYTE_W] && !r_clk_prev;
    assign w_byte   = r_smp[BYTE_W-1:0];

    assign w_next_blk = {r_shift[BLOCK_W-BYTE_W-1:0], w_byte};
    assign w_blk_done = (r_state == RECV) && !w_cs_n && w_strobe &&
                        (r_byte_cnt == c_LAST_BYTE);
    assign w_abort    = (r_state == RECV) && w_cs_n && (r_byte_cnt != '0);
    assign w_pop      = blk_ready && !w_empty;
    assign w_accept   = w_blk_done && (!w_full || w_pop);
    assign w_drop     = w_blk_done && w_full && !w_pop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_byte_cnt  <= '0;
            r_armed     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
            r_blk_count <= '0;
        end else begin
            if (w_cs_n) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (!w_cs_n && r_armed) begin
                        r_state <= RECV;
                    end
                end
                RECV: begin
                    // Chip-select release takes priority over a coincident strobe.
                    if (w_cs_n) begin
                        r_state    <= IDLE;
                        r_byte_cnt <= '0;
                    end else if (w_strobe) begin
                        r_shift    <= w_next_blk;
                        r_byte_cnt <= r_byte_cnt + c_BCNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_abort) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end

            if (w_accept) begin
                r_blk_count <= r_blk_count + c_CNT_ONE;
            end
        end
    end

    aes_spi_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BLOCK_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_accept),
        .i_data  (w_next_blk),
        .i_pop   (w_pop),
        .o_data  (blk_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign blk_valid = !w_empty;
    assign blk_count = r_blk_count;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_aes_spi_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aes_spi_rx
// Desc     : Scoreboard bench for aes_spi_rx; strobe timing follows
//            AES_SPI_RX_SYNC_EN (2 high / 2 low with it, 1 / 1 without).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_spi_rx;

    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;
`ifdef AES_SPI_RX_SYNC_EN
    localparam int LAT = 3;
    localparam int HI  = 2;
    localparam int LO  = 2;
`else
    localparam int LAT = 1;
    localparam int HI  = 1;
    localparam int LO  = 1;
`endif

    logic             clk = 1'b0;
    logic             resetn;
    logic [7:0]       spi_data;
    logic             spi_clk;
    logic             spi_cs_n;
    logic [127:0]     blk_data;
    logic             blk_valid;
    logic             blk_ready;
    logic [CNT_W-1:0] blk_count;
    logic             frame_err;
    logic             overflow;
    logic             err_clr;

    logic [127:0] exp_q[$];
    logic [127:0] mon_exp;
    int           n_cmp = 0;
    int           n_err = 0;
    int           exp_count = 0;

    always #5 clk = ~clk;

    aes_spi_rx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .spi_data  (spi_data),
        .spi_clk   (spi_clk),
        .spi_cs_n  (spi_cs_n),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_count (blk_count),
        .frame_err (frame_err),
        .overflow  (overflow),
        .err_clr   (err_clr)
    );

    // Output monitor: every handshake is checked against the scoreboard head.
    always begin
        @(negedge clk);
        #1;
        if (resetn && blk_valid && blk_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got %h, required no block", blk_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (blk_data !== mon_exp) begin
                    n_err++;
                    $display("FAIL blk_data: got %h, required %h", blk_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        spi_data = b;
        spi_clk  = 1'b0;
        repeat (LO) @(negedge clk);
        spi_clk  = 1'b1;
        repeat (HI) @(negedge clk);
    endtask

    task automatic frame_start();
        spi_clk  = 1'b0;
        spi_cs_n = 1'b0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic frame_end();
        spi_clk = 1'b0;
        repeat (2) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (LAT + 3) @(negedge clk);
    endtask

    task automatic send_block(input logic [7:0] base, input bit exp_push, input bit pop_on_last);
        logic [127:0] blk;
        logic [7:0]   b;
        blk = '0;
        for (int i = 0; i < 16; i++) begin
            b   = base + 8'(i);
            blk = {blk[119:0], b};
            send_byte(b);
        end
        if (exp_push) exp_q.push_back(blk);
        if (pop_on_last) begin
            repeat (LAT - HI) @(negedge clk);
            blk_ready = 1'b1;
            @(negedge clk);
            blk_ready = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || blk_valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || blk_valid) begin
            n_err++;
            $display("FAIL drain_timeout: pending=%0d valid=%b, required 0/0", exp_q.size(), blk_valid);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; spi_data = '0; spi_clk = 1'b0; spi_cs_n = 1'b1;
        blk_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        n_cmp += 5;
        if (blk_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", blk_valid); end
        if (blk_data !== 128'h0) begin n_err++; $display("FAIL rst_data: got %h, required 0", blk_data); end
        if (blk_count !== 16'd0) begin n_err++; $display("FAIL rst_count: got %0d, required 0", blk_count); end
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %b, required 0", frame_err); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
    endtask

    task automatic test_single_block();
        logic [127:0] want;
        want = 128'h000102030405060708090a0b0c0d0e0f;
        blk_ready = 1'b0;
        frame_start();
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        exp_q.push_back(want);
        exp_count++;
        repeat (LAT - HI) @(negedge clk);
        n_cmp++;
        if (blk_valid !== 1'b0) begin n_err++; $display("FAIL valid_early: got %b, required 0", blk_valid); end
        @(negedge clk);
        n_cmp += 5;
        if (blk_valid !== 1'b1) begin n_err++; $display("FAIL valid_latency: got %b, required 1", blk_valid); end
        if (blk_data !== want) begin n_err++; $display("FAIL single_data: got %h, required %h", blk_data, want); end
        if (blk_count !== 16'(exp_count)) begin n_err++; $display("FAIL single_count: got %0d, required %0d", blk_count, exp_count); end
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL single_frame_err: got %b, required 0", frame_err); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL single_overflow: got %b, required 0", overflow); end
        frame_end();
        blk_ready = 1'b1;
        wait_drain(50);
    endtask

    task automatic test_back_to_back();
        blk_ready = 1'b1;
        frame_start();
        for (int k = 0; k < 3; k++) send_block(8'h40 + 8'(16 * k), 1'b1, 1'b0);
        exp_count += 3;
        frame_end();
        wait_drain(100);
        n_cmp += 2;
        if (blk_count !== 16'(exp_count)) begin n_err++; $display("FAIL b2b_count: got %0d, required %0d", blk_count, exp_count); end
        if (frame_err !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL b2b_flags: got %b%b, required 00", frame_err, overflow); end
    endtask

    task automatic test_overflow();
        blk_ready = 1'b0;
        frame_start();
        for (int k = 0; k < 5; k++) send_block(8'h80 + 8'(7 * k), (k < 4), 1'b0);
        exp_count += 4;
        frame_end();
        n_cmp += 3;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b, required 1", overflow); end
        if (blk_count !== 16'(exp_count)) begin n_err++; $display("FAIL ovf_count: got %0d, required %0d", blk_count, exp_count); end
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL ovf_frame_err: got %b, required 0", frame_err); end
        blk_ready = 1'b1;
        wait_drain(50);
        blk_ready = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b, required 0", overflow); end

        // Fifth block lands in the same cycle as a pop of the full FIFO.
        frame_start();
        for (int k = 0; k < 5; k++) send_block(8'hC0 + 8'(5 * k), 1'b1, (k == 4));
        exp_count += 5;
        frame_end();
        n_cmp += 2;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pop_same_cycle: got %b, required 0", overflow); end
        if (blk_count !== 16'(exp_count)) begin n_err++; $display("FAIL ovf_pop_count: got %0d, required %0d", blk_count, exp_count); end
        blk_ready = 1'b1;
        wait_drain(50);
    endtask

    task automatic test_frame_err();
        blk_ready = 1'b1;
        frame_start();
        for (int i = 0; i < 7; i++) send_byte(8'hA0 + 8'(i));
        frame_end();
        n_cmp += 3;
        if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_set: got %b, required 1", frame_err); end
        if (blk_count !== 16'(exp_count)) begin n_err++; $display("FAIL ferr_count: got %0d, required %0d", blk_count, exp_count); end
        if (blk_valid !== 1'b0) begin n_err++; $display("FAIL ferr_valid: got %b, required 0", blk_valid); end
        frame_start();
        send_block(8'h11, 1'b1, 1'b0);
        exp_count++;
        frame_end();
        wait_drain(50);
        n_cmp += 2;
        if (blk_count !== 16'(exp_count)) begin n_err++; $display("FAIL ferr_next_count: got %0d, required %0d", blk_count, exp_count); end
        if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_sticky: got %b, required 1", frame_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (frame_err !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL ferr_clr: got %b%b, required 00", frame_err, overflow); end
    endtask

    task automatic test_reset_mid_frame();
        blk_ready = 1'b0;
        frame_start();
        for (int i = 0; i < 3; i++) send_byte(8'h55);
        frame_end();
        frame_start();
        send_block(8'h20, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) send_byte(8'h90 + 8'(i));
        resetn = 1'b0;
        #1;
        n_cmp += 5;
        if (blk_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b, required 0", blk_valid); end
        if (blk_data !== 128'h0) begin n_err++; $display("FAIL mid_rst_data: got %h, required 0", blk_data); end
        if (blk_count !== 16'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d, required 0", blk_count); end
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_frame_err: got %b, required 0", frame_err); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_rst_overflow: got %b, required 0", overflow); end
        exp_count = 0;
        spi_clk = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        // Strobes while chip-select was already low at release must be ignored.
        for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i));
        frame_end();
        n_cmp += 2;
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL mid_stale_frame_err: got %b, required 0", frame_err); end
        if (blk_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale_valid: got %b, required 0", blk_valid); end
        blk_ready = 1'b1;
        frame_start();
        send_block(8'h31, 1'b1, 1'b0);
        exp_count++;
        frame_end();
        wait_drain(50);
        n_cmp += 2;
        if (blk_count !== 16'(exp_count)) begin n_err++; $display("FAIL mid_clean_count: got %0d, required %0d", blk_count, exp_count); end
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL mid_clean_frame_err: got %b, required 0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_overflow();
        test_frame_err();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_spi_rx.md
# aes_spi_rx

Receive-side deframer for the AES co-processor's 8-lane parallel SPI output. It samples the byte lanes on each strobe rising edge while chip-select is asserted and reassembles every 16 bytes into one 128-bit ciphertext block. Completed blocks are buffered in a small FIFO and presented on a valid/ready stream for a checker, UART bridge or DMA sink. It sits directly downstream of the SoC's `spi_data`/`spi_clk`/`spi_cs_n` pins, either on the same FPGA as a loopback monitor or on a second board.

## Interface
- `FIFO_DEPTH`, default 4: block FIFO depth in 128-bit entries. Must be a power of two, ≥2.
- `CNT_W`, default 16: width of the completed-block counter.

Ports:
- `clk`  in  1  system clock. One clock domain for the whole block.
- `resetn`  in  1  reset. Asynchronous and active-low.
- `spi_data`  in  8  parallel byte lanes.
- `spi_clk`  in  1  byte strobe. Data is valid on its rising edge.
- `spi_cs_n`  in  1  frame enable, active low.
- `blk_data`  out  128  assembled block. First received byte is in [127:120]; last byte is in [7:0].
- `blk_valid`  out  1  FIFO non-empty.
- `blk_ready`  in  1  consumer accepts the head entry when `blk_valid && blk_ready`.
- `blk_count`  out  CNT_W  blocks pushed into the FIFO since reset. Wraps modulo 2^CNT_W.
- `frame_err`  out  1  sticky. Chip-select deasserted with a partial block.
- `overflow`  out  1  sticky. A block completed while the FIFO was full and no pop occurred that cycle.
- `err_clr`  in  1  synchronous pulse that clears `frame_err` and `overflow`.

## Operation
- Reset values:
  - `blk_valid`=0, `blk_data`=0, `blk_count`=0, `frame_err`=0, `overflow`=0.
  - FIFO empty, byte counter 0, FSM in IDLE.
- Input sampling:
  - Strobe edge = sampled `spi_clk` is 1 and its previous sample is 0.
  - `spi_data` and `spi_cs_n` are sampled through the same-depth path as `spi_clk`, so all three stay aligned.
- FSM, two states:
  - IDLE: the shift register is held. The FSM moves to RECV when sampled `cs_n`=0.
  - RECV, on a strobe edge:
    - Shift the sampled byte into the low end of the 128-bit shift register.
    - Increment the 4-bit byte counter.
  - RECV, 16th byte (counter 15 → 0):
    - The completed block, including the current byte, is pushed into the FIFO and `blk_count` increments.
    - The FSM stays in RECV.
  - RECV, sampled `cs_n`=1:
    - Return to IDLE.
    - If the byte counter ≠ 0, set `frame_err`, discard the partial block and zero the counter.
    - A strobe edge in the same cycle that `cs_n` rises is ignored.
- Push while FIFO is full:
  - If `blk_ready && blk_valid` that cycle, the pop and the push both occur and no data is lost.
  - Otherwise the new block is dropped, `overflow` is set and `blk_count` does not increment.
- `err_clr` and a set event in the same cycle: set wins.
- `blk_data` always shows the FIFO head. Its value is don't-care while `blk_valid`=0.
- Reset asserted mid-frame: everything returns to reset values immediately. Partial data is lost, with no error flag. After release, bytes are only accepted once a fresh `cs_n` falling edge has been observed. Any strobe seen while `cs_n` was already low at release is ignored until IDLE has been entered.

## Timing
- `blk_valid` rises 1 cycle after the edge-detect cycle of the 16th byte. FIFO write latency is 1.
- With synchronizers enabled, the latency from an `spi_clk` pin rising to the edge-detect cycle is 3 cycles. Without them it is 1 cycle.
- Pop is registered: the next head appears on `blk_data` the cycle after the handshake.
- Simultaneous pop and push on an empty FIFO is impossible, because valid is 0. On a one-entry FIFO, the count stays at 1.
- Source constraints with synchronizers enabled:
  - `spi_clk` high ≥2 `clk` cycles and low ≥2 `clk` cycles.
  - Data stable from 1 cycle before to 1 cycle after the strobe rise.

## Configuration
- `AES_SPI_RX_SYNC_EN` defined: 2-flop synchronizers on `spi_clk`, `spi_cs_n` and all 8 `spi_data` lanes, for use when the source is on another board or clock.
- Not defined: single register stage only. The source must share `clk`, and a 1-cycle-high strobe is legal.

## Structure
- Package `aes_spi_rx_pkg` holds:
  - `BLOCK_BYTES`=16 and `BLOCK_W`=128.
  - The FSM state enum (IDLE, RECV).
- Sub-module `aes_spi_rx_fifo`: a synchronous FIFO with parameterised depth and width.
  - Inputs: push, pop. Outputs: full, empty.
  - Registered head output.
  - Reset is asynchronous and active-low.

## Test plan
- 16 strobes with `cs_n` low, bytes 0x00..0x0F → one block, `blk_data`=0x000102…0F, `blk_count`=1, no flags.
- Frame of 48 bytes with `blk_ready`=1 → three blocks in order, `blk_count`=3.
- `blk_ready`=0 throughout, 5 blocks sent, `FIFO_DEPTH`=4 → `overflow`=1, `blk_count`=4, and the first 4 blocks drain intact. Repeat with a pop in the same cycle as the 5th push → no overflow, `blk_count`=5.
- 7 bytes, then `cs_n` high → `frame_err`=1 and nothing pushed. The next full frame is received correctly. `err_clr` → both flags 0.
- `resetn` pulsed low after 9 bytes → all outputs return to reset values. A following clean frame yields a correct block and `frame_err`=0.
- Macro enabled, strobe held for exactly 2 high / 2 low cycles → every byte captured. Macro disabled, strobe 1 cycle high → every byte captured.
